// File: rtl/m_seq_pkg.sv
// Shared definitions for the m-sequence generator/decoder pair: defaults,
// FSM encoding and the code <-> start-phase mapping.
package m_seq_pkg;

    localparam int unsigned POLYNOME_DEF = 32'b100111;
    localparam int          N_DEF        = 63;
    localparam int          M_LEN        = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } dec_state_t;

    // Code c is the generator start phase reached after c LFSR steps from
    // 6'b101010. Entry 63 is unused (the all-zero phase never appears).
    function automatic logic [M_LEN-1:0] phase_of_code(input logic [M_LEN-1:0] code);
        logic [M_LEN-1:0] p;
        case (code)
            6'd0:  p = 6'b101010;  6'd1:  p = 6'b010101;  6'd2:  p = 6'b001010;
            6'd3:  p = 6'b100101;  6'd4:  p = 6'b110010;  6'd5:  p = 6'b011001;
            6'd6:  p = 6'b101100;  6'd7:  p = 6'b010110;  6'd8:  p = 6'b001011;
            6'd9:  p = 6'b000101;  6'd10: p = 6'b000010;  6'd11: p = 6'b100001;
            6'd12: p = 6'b010000;  6'd13: p = 6'b001000;  6'd14: p = 6'b000100;
            6'd15: p = 6'b100010;  6'd16: p = 6'b010001;  6'd17: p = 6'b101000;
            6'd18: p = 6'b110100;  6'd19: p = 6'b011010;  6'd20: p = 6'b101101;
            6'd21: p = 6'b110110;  6'd22: p = 6'b111011;  6'd23: p = 6'b111101;
            6'd24: p = 6'b111110;  6'd25: p = 6'b111111;  6'd26: p = 6'b011111;
            6'd27: p = 6'b101111;  6'd28: p = 6'b010111;  6'd29: p = 6'b101011;
            6'd30: p = 6'b110101;  6'd31: p = 6'b111010;  6'd32: p = 6'b011101;
            6'd33: p = 6'b001110;  6'd34: p = 6'b000111;  6'd35: p = 6'b100011;
            6'd36: p = 6'b110001;  6'd37: p = 6'b011000;  6'd38: p = 6'b001100;
            6'd39: p = 6'b100110;  6'd40: p = 6'b110011;  6'd41: p = 6'b111001;
            6'd42: p = 6'b011100;  6'd43: p = 6'b101110;  6'd44: p = 6'b110111;
            6'd45: p = 6'b011011;  6'd46: p = 6'b001101;  6'd47: p = 6'b000110;
            6'd48: p = 6'b000011;  6'd49: p = 6'b000001;  6'd50: p = 6'b100000;
            6'd51: p = 6'b110000;  6'd52: p = 6'b111000;  6'd53: p = 6'b111100;
            6'd54: p = 6'b011110;  6'd55: p = 6'b001111;  6'd56: p = 6'b100111;
            6'd57: p = 6'b010011;  6'd58: p = 6'b001001;  6'd59: p = 6'b100100;
            6'd60: p = 6'b010010;  6'd61: p = 6'b101001;  6'd62: p = 6'b010100;
            default: p = 6'b000000;
        endcase
        return p;
    endfunction

    // Inverse lookup; phases not in the table (only zero) decode to code 0.
    function automatic logic [M_LEN-1:0] code_of_phase(input logic [M_LEN-1:0] phase);
        logic [M_LEN-1:0] c;
        c = '0;
        for (int i = 0; i < 63; i++) begin
            if (phase_of_code(M_LEN'(i)) == phase) c = M_LEN'(i);
        end
        return c;
    endfunction

endpackage

// File: rtl/m_seq_lfsr.sv
// Prediction LFSR. A load captures the received start phase already advanced
// LENGTH steps, so bit0 is the prediction for chip LENGTH onwards.
module m_seq_lfsr #(
    parameter int          LENGTH   = 6,
    parameter int unsigned POLYNOME = 32'b100111
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LENGTH-1:0] load_val,
    output logic [LENGTH-1:0] state,
    output logic              bit0
);

    localparam logic [LENGTH-1:0] TAPS = LENGTH'(POLYNOME);

    function automatic logic [LENGTH-1:0] lfsr_next(input logic [LENGTH-1:0] s);
        return {^(TAPS & s), s[LENGTH-1:1]};
    endfunction

    logic [LENGTH-1:0] adv;

    // Skip past the LENGTH chips that were consumed as the start phase.
    always_comb begin
        adv = load_val;
        for (int i = 0; i < LENGTH; i++) adv = lfsr_next(adv);
    end

    // State register: load wins over step.
    always_ff @(posedge clkin) begin
        if (rst)       state <= '0;
        else if (load) state <= adv;
        else if (step) state <= lfsr_next(state);
    end

    assign bit0 = state[0];

endmodule

// File: rtl/m_sequence_decoder.sv
// M-sequence decoder: captures the start phase from the first LENGTH chips,
// checks the rest of the frame against the predicted sequence and reports
// the recovered code with a mismatch count.
module m_sequence_decoder
    import m_seq_pkg::*;
#(
    parameter int unsigned POLYNOME = POLYNOME_DEF,
    parameter int          N        = N_DEF,
    parameter int          LENGTH   = $clog2(N),
    parameter int          HOLD     = 3,
    parameter int          MAX_ERR  = 4
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              in,
    input  logic              strobe_i,
    output logic [LENGTH-1:0] code_o,
    output logic              code_valid_o,
    output logic [LENGTH-1:0] mism_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int SW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [SW-1:0]     SUB_SAMPLE = SW'(HOLD / 2);
    localparam logic [SW-1:0]     SUB_LAST   = SW'(HOLD - 1);
    localparam logic [LENGTH-1:0] MISM_MAX   = '1;

    dec_state_t        state, state_n, eff_state;
    logic [SW-1:0]     sub, sub_n, eff_sub;
    logic [CW-1:0]     chip, chip_n, eff_chip;
    logic [LENGTH-1:0] mism, mism_n, eff_mism;
    logic [LENGTH-1:0] phase0, phase_n;
    logic [LENGTH-1:0] lfsr_state;
    logic              start, sample, lfsr_load, lfsr_step, finish, pred, zero_seq;

    assign start = strobe_i && valid_i;

    // A zero start phase leaves the LFSR stuck at zero; every nonzero phase
    // stays nonzero, so this flags the degenerate frame during CHECK.
    assign zero_seq = (lfsr_state == '0);

    // FSM state register.
    always_ff @(posedge clkin) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and counter/compare datapath. A strobe in any state is
    // treated as if the FSM were already in LOAD at chip 0, sub 0.
    always_comb begin
        eff_state = start ? LOAD : state;
        eff_sub   = start ? '0 : sub;
        eff_chip  = start ? '0 : chip;
        eff_mism  = start ? '0 : mism;
        state_n   = eff_state;
        sub_n     = eff_sub;
        chip_n    = eff_chip;
        mism_n    = eff_mism;
        phase_n   = phase0;
        sample    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        finish    = 1'b0;
        case (eff_state)
            LOAD, CHECK: begin
                if (!valid_i) begin
                    state_n = IDLE;
                    sub_n   = '0;
                    chip_n  = '0;
                    mism_n  = '0;
                end else begin
                    sub_n  = (eff_sub == SUB_LAST) ? '0 : eff_sub + 1'b1;
                    sample = (eff_sub == SUB_SAMPLE);
                    if (sample) begin
                        chip_n = eff_chip + 1'b1;
                        if (eff_state == LOAD) begin
                            for (int k = 0; k < LENGTH; k++) begin
                                if (eff_chip == CW'(k)) phase_n[k] = in;
                            end
                            if (eff_chip == CW'(LENGTH - 1)) begin
                                state_n   = CHECK;
                                lfsr_load = 1'b1;
                            end
                        end else begin
                            lfsr_step = 1'b1;
                            if ((in != pred) && (eff_mism != MISM_MAX)) mism_n = eff_mism + 1'b1;
                            if (eff_chip == CW'(N - 1)) begin
                                state_n = DONE;
                                finish  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                sub_n   = '0;
                chip_n  = '0;
                mism_n  = '0;
            end
        endcase
    end

    // Counters and captured phase.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sub    <= '0;
            chip   <= '0;
            mism   <= '0;
            phase0 <= '0;
        end else begin
            sub    <= sub_n;
            chip   <= chip_n;
            mism   <= mism_n;
            phase0 <= phase_n;
        end
    end

    // Result registers: updated on the final sample, held until the next one.
    always_ff @(posedge clkin) begin
        if (rst) begin
            code_valid_o <= 1'b0;
            code_o       <= '0;
            mism_o       <= '0;
            err_o        <= 1'b0;
        end else begin
            code_valid_o <= finish;
            if (finish) begin
                code_o <= (phase0 == '0) ? '0 : LENGTH'(code_of_phase(M_LEN'(phase0)));
                mism_o <= mism_n;
                err_o  <= (32'(mism_n) > MAX_ERR) || zero_seq;
            end
        end
    end

    assign busy_o = (state == LOAD) || (state == CHECK);

    m_seq_lfsr #(
        .LENGTH   (LENGTH),
        .POLYNOME (POLYNOME)
    ) u_lfsr (
        .clkin    (clkin),
        .rst      (rst),
        .load     (lfsr_load),
        .step     (lfsr_step),
        .load_val (phase_n),
        .state    (lfsr_state),
        .bit0     (pred)
    );

endmodule

// File: tb/tb_m_sequence_decoder.sv
// Directed bench for m_sequence_decoder with a result scoreboard.
module tb_m_sequence_decoder;

    localparam int N       = 63;
    localparam int LENGTH  = 6;
    localparam int HOLD    = 3;
    localparam int MAX_ERR = 4;

    typedef struct {
        logic [5:0] code;
        logic [5:0] mism;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clkin = 1'b0;
    logic       rst, valid_i, in, strobe_i;
    logic [5:0] code_o, mism_o;
    logic       code_valid_o, err_o, busy_o;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    m_sequence_decoder #(
        .POLYNOME (32'b100111),
        .N        (N),
        .LENGTH   (LENGTH),
        .HOLD     (HOLD),
        .MAX_ERR  (MAX_ERR)
    ) dut (
        .clkin        (clkin),
        .rst          (rst),
        .valid_i      (valid_i),
        .in           (in),
        .strobe_i     (strobe_i),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .mism_o       (mism_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    initial forever #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] lstep(input logic [5:0] s);
        return {^(s & 6'b100111), s[5:1]};
    endfunction

    // Generator start phase for a code: that many steps on from 101010.
    function automatic logic [5:0] phase_for(input int c);
        logic [5:0] s;
        s = 6'b101010;
        for (int i = 0; i < c; i++) s = lstep(s);
        return s;
    endfunction

    // Entered and left on a negedge; drives nchips chips of the sequence
    // starting at st, the last one held for tail cycles.
    task automatic drive_frame(input logic [5:0] st, input logic [62:0] flip,
                               input int nchips, input int tail);
        logic [5:0] s;
        s = st;
        for (int k = 0; k < nchips; k++) begin
            for (int h = 0; h < ((k == nchips - 1) ? tail : HOLD); h++) begin
                valid_i  = 1'b1;
                strobe_i = (k == 0 && h == 0);
                in       = s[0] ^ flip[k];
                @(negedge clkin);
            end
            s = lstep(s);
        end
        strobe_i = 1'b0;
    endtask

    // Full frame with its expected result queued before it is driven.
    task automatic send(input logic [5:0] st, input int code, input logic [62:0] flip, input int tail);
        exp_t e;
        int   m;
        m = 0;
        for (int k = LENGTH; k < N; k++) if (flip[k]) m++;
        if (m > 63) m = 63;
        e.code = (st == 6'd0) ? 6'd0 : 6'(code);
        e.mism = 6'(m);
        e.err  = (m > MAX_ERR) || (st == 6'd0);
        e.cyc  = cyc + 1 + HOLD / 2 + HOLD * (N - 1);
        sb.push_back(e);
        drive_frame(st, flip, N, tail);
    endtask

    task automatic idle(input int n);
        valid_i  = 1'b0;
        strobe_i = 1'b0;
        in       = 1'b0;
        repeat (n) @(negedge clkin);
    endtask

    // Monitor: every code_valid_o pulse must match the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(posedge clkin);
        cyc++;
        #1;
        if (code_valid_o === 1'b1) begin
            chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("code_o", 32'(code_o), 32'(e.code));
                chk("mism_o", 32'(mism_o), 32'(e.mism));
                chk("err_o", 32'(err_o), 32'(e.err));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; strobe_i = 1'b0; in = 1'b0;
        repeat (3) @(negedge clkin);
        chk("rst_code_o", 32'(code_o), 32'd0);
        chk("rst_mism_o", 32'(mism_o), 32'd0);
        chk("rst_err_o", 32'(err_o), 32'd0);
        chk("rst_valid", 32'(code_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        @(negedge clkin);

        // Clean code 0, then 25 and 49 back-to-back.
        send(phase_for(0), 0, 63'd0, HOLD);
        idle(5);
        send(phase_for(25), 25, 63'd0, HOLD);
        send(phase_for(49), 49, 63'd0, HOLD);
        idle(5);

        // Single error, threshold, and over-threshold frames.
        send(phase_for(12), 12, 63'd1 << 30, HOLD);
        idle(3);
        send(phase_for(40), 40, 63'hF << 50, HOLD);
        idle(3);
        send(phase_for(12), 12, 63'h7C00, HOLD);
        idle(3);

        // Reset in CHECK with a strobe present: outputs return to reset values.
        drive_frame(phase_for(20), 63'd0, 30, HOLD);
        chk("busy_mid_frame", 32'(busy_o), 32'd1);
        rst = 1'b1; valid_i = 1'b1; strobe_i = 1'b1;
        @(negedge clkin);
        chk("midrst_code_o", 32'(code_o), 32'd0);
        chk("midrst_mism_o", 32'(mism_o), 32'd0);
        chk("midrst_err_o", 32'(err_o), 32'd0);
        chk("midrst_valid", 32'(code_valid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0; strobe_i = 1'b0;
        idle(2);
        send(phase_for(44), 44, 63'd0, HOLD);
        idle(3);

        // Next frame strobed on the DONE cycle of the previous one.
        send(phase_for(7), 7, 63'd0, HOLD / 2 + 1);
        send(phase_for(33), 33, 63'd0, HOLD);
        idle(3);

        // All-zero start phase.
        send(6'd0, 0, 63'd0, HOLD);
        idle(3);

        // Restart at chip 20, then abort by valid_i low at chip 40.
        drive_frame(phase_for(5), 63'd0, 20, HOLD);
        send(phase_for(60), 60, 63'd0, HOLD);
        drive_frame(phase_for(3), 63'd0, 40, HOLD);
        chk("busy_before_abort", 32'(busy_o), 32'd1);
        idle(1);
        chk("busy_after_abort", 32'(busy_o), 32'd0);
        idle(200);
        chk("code_o_held", 32'(code_o), 32'd60);

        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clkin);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
